// File: rtl/seq_det_pkg.sv
// Shared constants for the serial sequence detector and related statistics blocks.
package seq_det_pkg;

    localparam int OVL_OFF   = 0;
    localparam int OVL_ON    = 1;

    localparam int OUT_MEALY = 0;
    localparam int OUT_REG   = 1;

    localparam int N_MIN     = 2;
    localparam int N_MAX     = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones, synchronous clear has priority over inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat
);

    assign sat = &count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with overlap / output-mode selection and a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int N       = 3,
    parameter     PATTERN = 3'b101,
    parameter int OVERLAP = OVL_ON,
    parameter int REG_OUT = OUT_MEALY,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             x,
    input  logic             clear,
    output logic             y,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    generate
        if (N < N_MIN || N > N_MAX || $bits(PATTERN) != N) begin : g_param_check
            $fatal(1, "seq_detector_param: N out of range or PATTERN width differs from N");
        end
    endgenerate

    localparam int            FILL_W   = $clog2(N);
    localparam logic [N-1:0]  PAT      = PATTERN;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N - 1);

    logic [N-2:0]      hist;
    logic [FILL_W-1:0] fill;
    logic [N-1:0]      window;
    logic              accept;
    logic              match;
    logic              y_q;

    assign accept = en && !clear;
    assign window = {hist, x};
    assign match  = accept && (fill == FILL_FULL) && (window == PAT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist <= '0;
            fill <= '0;
            y_q  <= 1'b0;
        end else begin
            y_q <= match;
            if (clear) begin
                hist <= '0;
                fill <= '0;
            end else if (en) begin
                // Non-overlapping mode throws the history away so the next match needs N fresh bits.
                if (match && OVERLAP == OVL_OFF) begin
                    hist <= '0;
                    fill <= '0;
                end else begin
                    hist <= window[N-2:0];
                    if (fill != FILL_FULL) begin
                        fill <= fill + FILL_W'(1);
                    end
                end
            end
        end
    end

    assign y = (REG_OUT == OUT_REG) ? y_q : match;

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clear),
        .inc     (match),
        .count   (match_count),
        .sat     (count_sat)
    );

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial sequence detector for single-bit input streams. It generalises the fixed 3-bit "101" Mealy detector to:
- any pattern of length N,
- selectable overlapping or non-overlapping matching,
- selectable combinational (Mealy) or registered output,
- a saturating match counter.

It sits after a serial receiver or bit-slicer and flags or counts sync words, framing markers or test patterns.

## Interface
Parameters:
- N, default 3: pattern length in bits; legal range 2..32.
- PATTERN, default 3'b101: N-bit pattern. PATTERN[N-1] is the first bit received.
- OVERLAP, default 1: 1 = overlapping matches allowed; 0 = after a match, the next match needs N fresh bits.
- REG_OUT, default 0: 0 = Mealy output, combinational from x; 1 = registered output, one cycle later.
- CNT_W, default 8: width of the match counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  bit-valid qualifier; x is consumed only when en=1.
- x  in  1  serial data bit.
- clear  in  1  synchronous clear of the match history and the counter.
- y  out  1  match pulse, one cycle wide per match.
- match_count  out  CNT_W  number of matches since reset/clear; saturating.
- count_sat  out  1  high while match_count equals all-ones.

## Operation
- Accepted bit: a cycle with en=1 and clear=0. Cycles with en=0 leave all state unchanged and produce no match.
- History: the detector holds the last up to N-1 accepted bits plus a fill count (0..N-1). The fill count is the number of valid history bits.
- Match: occurs on an accepted bit when both hold:
  - fill count = N-1;
  - {history, x} == PATTERN.
- History update on an accepted bit: shift in x; fill count increments, saturating at N-1.
- OVERLAP=0: on a match, the fill count resets to 0 and the history is discarded.
- OVERLAP=1: the history keeps shifting, so the pattern suffix can start the next match. For example, with PATTERN=101, the stream 10101 produces 2 matches.
- Counter: increments by 1 on each match while below 2^CNT_W-1. At all-ones it holds, and count_sat=1.
- clear=1:
  - fill count, history and match_count go to 0 on the next edge;
  - clear has priority over en: the bit presented that cycle is discarded and no match is reported.
- Reset (reset_n=0, asynchronous) forces: fill count 0, history 0, match_count 0, count_sat 0, registered y 0.

## Timing
- REG_OUT=0:
  - y = match condition, combinational in the accept cycle;
  - match_count updates at the closing edge of that cycle.
- REG_OUT=1:
  - y is asserted for exactly the cycle after the accept cycle;
  - match_count updates at the same edge that raises y.
- Reset mid-stream: the partial pattern is lost and a full N fresh bits are needed. A match whose registered y would have appeared after reset is suppressed.
- Back-to-back matches:
  - OVERLAP=1 with a self-overlapping pattern can match on consecutive accepted bits (e.g. PATTERN=11 with a stream of 1s), giving y high on consecutive cycles;
  - OVERLAP=0 guarantees at least N accepted bits between matches.
- Gaps: en=0 gaps of any length between bits do not break a partial match.
- clear and reset_n are the only inputs affecting the counter besides matches.
- Counter has no wrap-around.

## Structure
- Shared package seq_det_pkg holds:
  - the mode constants OVL_ON/OVL_OFF and OUT_MEALY/OUT_REG;
  - the legal-range limits (N_MIN=2, N_MAX=32) used for parameter checks.
- Elaboration-time check: N and PATTERN width must agree, and N must be within range. A violation is a fatal error.
- One sub-module: sat_counter, with parameter W and ports clk, reset_n, clr, inc, count, sat. It implements the saturating match counter and is reused by other statistics blocks.
- Detector core: history register, fill counter, compare logic and optional output register, all in seq_detector_param.

## Test plan
- Defaults (N=3, PATTERN=101, OVERLAP=1, REG_OUT=0): stream 1,0,1,0,1 with en=1 every cycle -> y high on bits 3 and 5 (same cycle); match_count=2.
- OVERLAP=0, same stream -> y only on bit 3; match_count=1. Then stream 1,0,1 -> y on the final bit of that stream; match_count=2.
- REG_OUT=1, N=4, PATTERN=1101, stream 1,1,0,1 with en gaps of 2 idle cycles between bits -> y high exactly one cycle after the last accepted bit; no y during the gaps.
- CNT_W=2, PATTERN=11, OVERLAP=1, eight consecutive 1s -> y on bits 2..8; match_count reaches 3, count_sat=1, and match_count holds at 3.
- clear=1 together with en=1, x=1 after a 1,0 prefix (PATTERN=101) -> no y; match_count=0. The following bits 1,0,1 -> y on the third bit.
- reset_n pulsed low mid-pattern after 1,0 -> y=0, match_count=0 immediately (asynchronous). The following bit 1 -> no match; a full 1,0,1 -> match.
